// File: rtl/ureg_pkg.sv
// ureg_pkg -- shared definitions for the AXI-Lite user register bank.
//   Byte offsets of the register map, AXI response codes and the
//   state types of the write and read channel FSMs.
package ureg_pkg;

    localparam int unsigned UREG_FIRMWARE_DATE = 32'h00;
    localparam int unsigned UREG_FIRMWARE_TIME = 32'h04;
    localparam int unsigned UREG_INFO          = 32'h08;
    localparam int unsigned UREG_TEST_BASE     = 32'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

endpackage

// File: rtl/ureg_bank_axil.sv
// ureg_bank_axil -- AXI-Lite slave exposing firmware identification
// registers and NUM_TEST read/write scratch registers.
//   ACLK, ARESETn            : clock, asynchronous active-low reset
//   AW*/W*/B*                : AXI-Lite write address/data/response channels
//   AR*/R*                   : AXI-Lite read address/data channels
//   test_regs                : scratch contents, TEST[i] at [32i+31:32i]
//   test_wr_pulse            : one-cycle strobe per scratch register write
module ureg_bank_axil
    import ureg_pkg::*;
#(
    parameter int          NUM_TEST = 2,
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] FW_DATE  = 32'h2024_0515,
    parameter logic [31:0] FW_TIME  = 32'h0012_3000
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [ADDR_W-1:0]        AWADDR,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [31:0]              WDATA,
    input  logic [3:0]               WSTRB,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    input  logic [ADDR_W-1:0]        ARADDR,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [31:0]              RDATA,
    output logic [1:0]               RRESP,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [32*NUM_TEST-1:0]   test_regs,
    output logic [NUM_TEST-1:0]      test_wr_pulse
);

    // Decoding works on word addresses; byte-lane bits are dropped.
    localparam int WA_W = ADDR_W - 2;
    localparam logic [WA_W-1:0] WORD_DATE = WA_W'(UREG_FIRMWARE_DATE / 4);
    localparam logic [WA_W-1:0] WORD_TIME = WA_W'(UREG_FIRMWARE_TIME / 4);
    localparam logic [WA_W-1:0] WORD_INFO = WA_W'(UREG_INFO / 4);
    localparam logic [WA_W-1:0] WORD_TEST = WA_W'(UREG_TEST_BASE / 4);
    localparam logic [WA_W-1:0] WORD_TEND = WA_W'(UREG_TEST_BASE / 4 + NUM_TEST);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

    logic [31:0] test_q [NUM_TEST];

    // ---------------- write path ----------------
    wstate_t          wstate_reg, wstate_next;
    logic             aw_held_reg, aw_held_next;
    logic             w_held_reg, w_held_next;
    logic [WA_W-1:0]  awaddr_reg;
    logic [31:0]      wdata_reg;
    logic [3:0]       wstrb_reg;
    logic             awready_reg, wready_reg, bvalid_reg;
    logic [1:0]       bresp_reg;

    logic             aw_hs, w_hs, wr_fire, wr_is_test;
    logic [WA_W-1:0]  wr_word;
    logic [31:0]      wr_data;
    logic [3:0]       wr_strb;

    assign aw_hs = AWVALID & awready_reg;
    assign w_hs  = WVALID & wready_reg;

    // A channel may be satisfied either by its latched copy or by a
    // handshake happening on this very edge, so the update never waits
    // an extra cycle once both halves are present.
    assign wr_fire = (wstate_reg == W_IDLE) & (aw_held_reg | aw_hs) & (w_held_reg | w_hs);
    assign wr_word = aw_held_reg ? awaddr_reg : AWADDR[ADDR_W-1:2];
    assign wr_data = w_held_reg ? wdata_reg : WDATA;
    assign wr_strb = w_held_reg ? wstrb_reg : WSTRB;
    assign wr_is_test = (wr_word >= WORD_TEST) && (wr_word < WORD_TEND);

    always_comb begin
        wstate_next  = wstate_reg;
        aw_held_next = aw_held_reg;
        w_held_next  = w_held_reg;
        case (wstate_reg)
            W_IDLE: begin
                if (wr_fire) begin
                    wstate_next  = W_RESP;
                    aw_held_next = 1'b0;
                    w_held_next  = 1'b0;
                end else begin
                    if (aw_hs) aw_held_next = 1'b1;
                    if (w_hs)  w_held_next  = 1'b1;
                end
            end
            W_RESP: begin
                if (BREADY) wstate_next = W_IDLE;
            end
            default: wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wstate_reg  <= W_IDLE;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            wstate_reg  <= wstate_next;
            aw_held_reg <= aw_held_next;
            w_held_reg  <= w_held_next;
            // READYs are registered: they drop after a capture and
            // reopen only once the response has been taken.
            awready_reg <= (wstate_next == W_IDLE) & ~aw_held_next;
            wready_reg  <= (wstate_next == W_IDLE) & ~w_held_next;
            if (aw_hs) awaddr_reg <= AWADDR[ADDR_W-1:2];
            if (w_hs) begin
                wdata_reg <= WDATA;
                wstrb_reg <= WSTRB;
            end
            if (wr_fire) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= wr_is_test ? RESP_OKAY : RESP_SLVERR;
            end else if ((wstate_reg == W_RESP) && BREADY) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    assign AWREADY = awready_reg;
    assign WREADY  = wready_reg;
    assign BVALID  = bvalid_reg;
    assign BRESP   = bresp_reg;

    // ---------------- scratch registers ----------------
    for (genvar gi = 0; gi < NUM_TEST; gi++) begin : g_test
        logic        hit;
        logic [31:0] test_reg;
        logic        pulse_reg;

        assign hit = wr_fire & (wr_word == (WORD_TEST + WA_W'(gi)));

        always_ff @(posedge ACLK or negedge ARESETn) begin
            if (!ARESETn) begin
                test_reg  <= '0;
                pulse_reg <= 1'b0;
            end else begin
                pulse_reg <= hit;
                if (hit) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) test_reg[8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end

        assign test_q[gi]               = test_reg;
        assign test_regs[32*gi +: 32]   = test_reg;
        assign test_wr_pulse[gi]        = pulse_reg;
    end

    // ---------------- read path ----------------
    rstate_t          rstate_reg, rstate_next;
    logic             arready_reg, rvalid_reg;
    logic [31:0]      rdata_reg, rd_mux;
    logic [1:0]       rresp_reg, rd_resp;
    logic             ar_hs;
    logic [WA_W-1:0]  rd_word;

    assign ar_hs   = ARVALID & arready_reg;
    assign rd_word = ARADDR[ADDR_W-1:2];

    always_comb begin
        rd_mux  = '0;
        rd_resp = RESP_OKAY;
        case (rd_word)
            WORD_DATE: rd_mux = FW_DATE;
            WORD_TIME: rd_mux = FW_TIME;
            WORD_INFO: rd_mux = {24'h0, 8'(NUM_TEST)};
            default: begin
                rd_resp = RESP_SLVERR;
                for (int i = 0; i < NUM_TEST; i++) begin
                    if (rd_word == (WORD_TEST + WA_W'(i))) begin
                        rd_mux  = test_q[i];
                        rd_resp = RESP_OKAY;
                    end
                end
            end
        endcase
    end

    always_comb begin
        rstate_next = rstate_reg;
        case (rstate_reg)
            R_IDLE:  if (ar_hs)  rstate_next = R_DATA;
            R_DATA:  if (RREADY) rstate_next = R_IDLE;
            default: rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rstate_reg  <= R_IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
        end else begin
            rstate_reg  <= rstate_next;
            arready_reg <= (rstate_next == R_IDLE);
            // Capturing on the AR edge samples scratch values before any
            // write landing on the same edge.
            if (ar_hs) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_mux;
                rresp_reg  <= rd_resp;
            end else if ((rstate_reg == R_DATA) && RREADY) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    assign ARREADY = arready_reg;
    assign RVALID  = rvalid_reg;
    assign RDATA   = rdata_reg;
    assign RRESP   = rresp_reg;

endmodule

// File: tb/tb_ureg_bank_axil.sv
module tb_ureg_bank_axil;

    logic        tb_ACLK = 1'b0;
    logic        ARESETn;
    logic [11:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [11:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [63:0] test_regs;
    logic [1:0]  test_wr_pulse;

    int total = 0;
    int bad   = 0;

    always #5 tb_ACLK = ~tb_ACLK;

    ureg_bank_axil dut (
        .ACLK          (tb_ACLK),
        .ARESETn       (ARESETn),
        .AWADDR        (AWADDR),
        .AWVALID       (AWVALID),
        .AWREADY       (AWREADY),
        .WDATA         (WDATA),
        .WSTRB         (WSTRB),
        .WVALID        (WVALID),
        .WREADY        (WREADY),
        .BRESP         (BRESP),
        .BVALID        (BVALID),
        .BREADY        (BREADY),
        .ARADDR        (ARADDR),
        .ARVALID       (ARVALID),
        .ARREADY       (ARREADY),
        .RDATA         (RDATA),
        .RRESP         (RRESP),
        .RVALID        (RVALID),
        .RREADY        (RREADY),
        .test_regs     (test_regs),
        .test_wr_pulse (test_wr_pulse)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] exp_resp, input logic [1:0] exp_pulse,
                            input string tag);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs, w_hs;
        int n = 0;
        AWADDR = a; AWVALID = 1'b1;
        WDATA = d; WSTRB = s; WVALID = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            step();
            n++;
            if (aw_hs) begin AWVALID = 1'b0; aw_done = 1; end
            if (w_hs)  begin WVALID  = 1'b0; w_done  = 1; end
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        chk({tag, "_hs"}, 64'(aw_done && w_done), 64'd1);
        chk({tag, "_bvalid"}, 64'(BVALID), 64'd1);
        chk({tag, "_bresp"}, 64'(BRESP), 64'(exp_resp));
        chk({tag, "_pulse"}, 64'(test_wr_pulse), 64'(exp_pulse));
        $display("wr addr=%h data=%h strb=%b bresp=%0d pulse=%b", a, d, s, BRESP, test_wr_pulse);
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        chk({tag, "_bdone"}, 64'(BVALID), 64'd0);
        chk({tag, "_pulse_clr"}, 64'(test_wr_pulse), 64'd0);
    endtask

    task automatic do_read(input logic [11:0] a, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input string tag);
        int n = 0;
        ARADDR = a; ARVALID = 1'b1;
        while (!ARREADY && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_arready"}, 64'(ARREADY), 64'd1);
        step();
        ARVALID = 1'b0;
        chk({tag, "_rvalid"}, 64'(RVALID), 64'd1);
        chk({tag, "_rdata"}, 64'(RDATA), 64'(exp_data));
        chk({tag, "_rresp"}, 64'(RRESP), 64'(exp_resp));
        $display("rd addr=%h data=%h rresp=%0d", a, RDATA, RRESP);
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
        chk({tag, "_rdone"}, 64'(RVALID), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETn = 1'b0;
        AWADDR = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;

        // reset state
        step(); step();
        chk("rst_awready", 64'(AWREADY), 64'd0);
        chk("rst_wready", 64'(WREADY), 64'd0);
        chk("rst_arready", 64'(ARREADY), 64'd0);
        chk("rst_valids", 64'({BVALID, RVALID}), 64'd0);
        chk("rst_resp_rdata", 64'({BRESP, RRESP, RDATA}), 64'd0);
        chk("rst_test_regs", test_regs, 64'd0);
        chk("rst_pulse", 64'(test_wr_pulse), 64'd0);
        ARESETn = 1'b1;
        step();
        chk("rel_readies", 64'({AWREADY, WREADY, ARREADY}), 64'b111);

        // identification registers
        do_read(12'h000, 32'h2024_0515, 2'b00, "rd_date");
        do_read(12'h004, 32'h0012_3000, 2'b00, "rd_time");
        do_read(12'h008, 32'h0000_0002, 2'b00, "rd_info");
        do_read(12'h006, 32'h0012_3000, 2'b00, "rd_time_bytebits");

        // scratch writes and readback
        do_write(12'h010, 32'hDEAD_BEAF, 4'hF, 2'b00, 2'b01, "wr_t0");
        do_write(12'h014, 32'h00A5_A5A5, 4'hF, 2'b00, 2'b10, "wr_t1");
        chk("regs_after_wr", test_regs, 64'h00A5_A5A5_DEAD_BEAF);
        do_read(12'h010, 32'hDEAD_BEAF, 2'b00, "rd_t0");
        do_read(12'h014, 32'h00A5_A5A5, 2'b00, "rd_t1");

        // W presented three cycles ahead of AW, partial strobes
        WDATA = 32'h1122_3344; WSTRB = 4'b0011; WVALID = 1'b1;
        step();
        WVALID = 1'b0;
        chk("early_w_wready", 64'(WREADY), 64'd0);
        step(); step();
        chk("early_w_nob", 64'(BVALID), 64'd0);
        chk("early_w_awready", 64'(AWREADY), 64'd1);
        chk("early_w_unchanged", test_regs[63:32], 64'h00A5_A5A5);
        AWADDR = 12'h014; AWVALID = 1'b1;
        step();
        AWVALID = 1'b0;
        chk("early_w_bvalid", 64'(BVALID), 64'd1);
        chk("early_w_bresp", 64'(BRESP), 64'd0);
        chk("early_w_pulse", 64'(test_wr_pulse), 64'b10);
        $display("wr addr=014 data=11223344 strb=0011 (w first) bresp=%0d", BRESP);
        BREADY = 1'b1; step(); BREADY = 1'b0;
        do_read(12'h014, 32'h00A5_3344, 2'b00, "rd_t1_strb");

        // error responses
        do_write(12'h000, 32'h0000_0001, 4'hF, 2'b10, 2'b00, "wr_ro");
        chk("wr_ro_regs", test_regs, 64'h00A5_3344_DEAD_BEAF);
        do_read(12'h000, 32'h2024_0515, 2'b00, "rd_date_again");
        do_read(12'h040, 32'h0, 2'b10, "rd_unmapped40");
        do_read(12'h00C, 32'h0, 2'b10, "rd_unmapped0c");
        do_write(12'h018, 32'hFFFF_FFFF, 4'hF, 2'b10, 2'b00, "wr_past_end");

        // zero strobe still pulses, data unchanged
        do_write(12'h010, 32'hFFFF_FFFF, 4'h0, 2'b00, 2'b01, "wr_strb0");
        chk("strb0_regs", test_regs[31:0], 64'hDEAD_BEAF);

        // read and write of the same register on one edge
        AWADDR = 12'h014; AWVALID = 1'b1;
        WDATA = 32'h5566_7788; WSTRB = 4'hF; WVALID = 1'b1;
        ARADDR = 12'h014; ARVALID = 1'b1;
        step();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        chk("same_rvalid", 64'({RVALID, BVALID}), 64'b11);
        chk("same_rdata_old", 64'(RDATA), 64'h00A5_3344);
        chk("same_newval", test_regs[63:32], 64'h5566_7788);
        $display("rd+wr addr=014 rdata=%h new=%h", RDATA, test_regs[63:32]);
        BREADY = 1'b1; RREADY = 1'b1; step(); BREADY = 1'b0; RREADY = 1'b0;
        chk("same_done", 64'({RVALID, BVALID}), 64'b00);

        // write response backpressure
        AWADDR = 12'h010; AWVALID = 1'b1;
        WDATA = 32'h1234_5678; WSTRB = 4'hF; WVALID = 1'b1;
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_b_hold", 64'({BVALID, BRESP, AWREADY, WREADY}), 64'b1_00_0_0);
            step();
        end
        BREADY = 1'b1; step(); BREADY = 1'b0;
        chk("bp_b_done", 64'({BVALID, AWREADY, WREADY}), 64'b0_1_1);
        $display("wr addr=010 data=12345678 (bready held off 5 cycles)");

        // read data backpressure
        ARADDR = 12'h010; ARVALID = 1'b1;
        step();
        ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_r_hold", 64'({RVALID, ARREADY, RRESP, RDATA}), {29'd0, 1'b1, 1'b0, 2'b00, 32'h1234_5678});
            step();
        end
        RREADY = 1'b1; step(); RREADY = 1'b0;
        chk("bp_r_done", 64'({RVALID, ARREADY}), 64'b01);
        $display("rd addr=010 data=12345678 (rready held off 5 cycles)");

        // reset with AW latched and W pending
        AWADDR = 12'h010; AWVALID = 1'b1;
        step();
        AWVALID = 1'b0;
        chk("mid_aw_latched", 64'({AWREADY, WREADY}), 64'b01);
        ARESETn = 1'b0;
        #1;
        chk("mid_rst_async", 64'({AWREADY, WREADY, ARREADY}), 64'd0);
        chk("mid_rst_regs", test_regs, 64'd0);
        step();
        ARESETn = 1'b1;
        step();
        chk("mid_rel_readies", 64'({AWREADY, WREADY, ARREADY}), 64'b111);
        chk("mid_rel_regs", test_regs, 64'd0);
        do_write(12'h014, 32'hCAFE_F00D, 4'hF, 2'b00, 2'b10, "wr_after_rst");
        chk("after_rst_regs", test_regs, 64'hCAFE_F00D_0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
